fifo_uart_tx: RTL
=================

# fifo_uart_tx

Serial transmitter that drains bytes from the 16-deep 8-bit synchronous FIFO and shifts each one out as an asynchronous UART frame (start, 8 data bits LSB first, optional parity, one stop bit). Sits directly downstream of the FIFO: it drives the FIFO pop input and consumes its `empty` flag and `dout` bus. It never pops an empty FIFO, so FIFO underrun is never triggered by this block.

## Interface
- `DATA_W`, 8: frame data width; FIFO data width.
- `DIV_W`, 16: width of the baud divisor.
- `clk`  in  1  single clock; all logic rising-edge.
- `rst`  in  1  asynchronous, active-high reset.
- `en`  in  1  transmit enable. Low stops new frames; an in-flight frame always completes.
- `baud_div`  in  DIV_W  bit period minus one, in clocks (period = baud_div+1). Latched per frame.
- `parity_en`  in  1  1 = insert parity bit. Latched per frame.
- `parity_odd`  in  1  1 = odd parity, 0 = even. Latched per frame.
- `fifo_empty`  in  1  FIFO empty flag.
- `fifo_dout`  in  DATA_W  FIFO read data, valid the cycle after the pop is sampled.
- `pop_out`  out  1  one-cycle pop request to the FIFO (drives its `pop_in`).
- `tx`  out  1  serial line, idle high, registered.
- `busy`  out  1  high in every state except IDLE.
- `frame_done`  out  1  one-cycle pulse in the last clock of the stop bit.

## Operation
- Reset values: `tx`=1, `pop_out`=0, `busy`=0, `frame_done`=0, state IDLE, counters 0.
- States: IDLE, POP, LOAD, START, DATA, PARITY, STOP.
- IDLE: if `en` && !`fifo_empty` -> POP; else stay.
- POP: `pop_out`=1 for exactly this cycle -> LOAD.
- LOAD: capture `fifo_dout` into the shift register; latch `baud_div`, `parity_en`, `parity_odd`; compute parity (even = XOR of the 8 data bits, odd = its inverse) -> START.
- START: `tx`=0 for one bit period -> DATA.
- DATA: `tx`=shift[0] each bit period; shift right; 3-bit index counts 0..7; after bit 7 -> PARITY if latched `parity_en`, else STOP.
- PARITY: `tx`=parity bit for one bit period -> STOP.
- STOP: `tx`=1 for one bit period; `frame_done`=1 in its final clock. Exit: if `en` && !`fifo_empty` -> POP (skips IDLE), else -> IDLE.
- Bit period counter: DIV_W bits, loaded with the latched divisor on entry to each bit, decrements to 0; the bit ends in the clock where it reads 0. `baud_div`=0 gives one clock per bit.
- `en` low mid-frame: frame finishes normally, then IDLE. `baud_div`/parity inputs changing mid-frame: ignored until the next LOAD.
- Reset mid-frame: asynchronous return to reset values; `tx` goes high immediately; the byte in flight is dropped (it was already popped).
- `fifo_empty` is sampled only in IDLE and at STOP exit; no pop is ever issued while it is high.

## Timing
- `en`=1, `fifo_empty`=0 sampled in IDLE at edge k: `pop_out` high in cycle k..k+1, LOAD in k+1..k+2, `tx` falls at edge k+3.
- Frame length: (10 + parity_en) × (baud_div+1) clocks, start edge to end of stop.
- Back-to-back frames: 2 extra idle-high clocks (POP, LOAD) between stop end and next start bit.
- `frame_done` and `busy` are registered; `busy` falls on the edge entering IDLE.

## Structure
- Shared package `uart_pkg`: state enum, `DATA_W` default, `DIV_W` default.
- One sub-module: `uart_baud_counter` (loadable down-counter, outputs `bit_end` when count is 0).
- Top holds the FSM, shift register, bit index and parity register.

## Test plan
- `baud_div`=3, no parity, FIFO holds 0xA5 -> one pop; `tx` = 0,1,0,1,0,0,1,0,1,1 each held 4 clocks; `frame_done` at clock 40 of the frame.
- Same byte, `parity_en`=1: `parity_odd`=0 -> parity bit 0; `parity_odd`=1 -> parity bit 1; frame 44 clocks.
- FIFO preloaded with 0x00, 0xFF, 0x3C, `baud_div`=0 -> three pops, frames of 10 clocks separated by exactly 2 high clocks, FIFO `empty` after the third pop, no `underrun`.
- `fifo_empty`=1 with `en`=1 for 100 clocks -> `pop_out` never asserts, `tx`=1, `busy`=0.
- Drop `en` during DATA bit 3 of 0x5A with more data queued -> frame completes, no further pop, IDLE.
- Assert `rst` for 1 clock in DATA -> `tx`=1 in the same cycle, all outputs at reset values; after release, next queued byte is popped and sent intact.

Source files
------------

// File: rtl/fifo_uart_tx_pkg.sv
// Shared types and defaults for the FIFO-fed UART transmitter.
package fifo_uart_tx_pkg;

   localparam int DATA_W_DEF = 8;
   localparam int DIV_W_DEF  = 16;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_POP,
      ST_LOAD,
      ST_START,
      ST_DATA,
      ST_PARITY,
      ST_STOP
   } state_e;

   // Even parity is the XOR of the data bits; odd parity is its inverse.
   function automatic logic calc_parity(input logic [DATA_W_DEF-1:0] d, input logic odd);
      return (^d) ^ odd;
   endfunction

endpackage

// File: rtl/fifo_uart_tx_if.sv
// FIFO read-side handshake between the transmitter (master) and the FIFO (slave).
interface fifo_uart_tx_if import fifo_uart_tx_pkg::*; #(parameter int DATA_W = DATA_W_DEF) ();

   logic              pop_out;
   logic              fifo_empty;
   logic [DATA_W-1:0] fifo_dout;

   modport master (output pop_out, input fifo_empty, input fifo_dout);
   modport slave  (input pop_out, output fifo_empty, output fifo_dout);

endinterface

// File: rtl/fifo_uart_tx_baud_counter.sv
// Loadable bit-period down-counter; o_bit_end marks the last clock of a bit.
module fifo_uart_tx_baud_counter import fifo_uart_tx_pkg::*; #(
   parameter int DIV_W = DIV_W_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_load,
   input  logic [DIV_W-1:0] i_div,
   output logic             o_bit_end
);

   logic [DIV_W-1:0] r_cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)                r_cnt <= '0;
      else if (i_load)        r_cnt <= i_div;
      else if (r_cnt != '0)   r_cnt <= r_cnt - DIV_W'(1);
   end

   assign o_bit_end = (r_cnt == '0);

endmodule

// File: rtl/fifo_uart_tx.sv
// UART transmitter draining a synchronous FIFO: start, 8 data LSB first, optional parity, stop.
module fifo_uart_tx import fifo_uart_tx_pkg::*; #(
   parameter int DATA_W = DATA_W_DEF,
   parameter int DIV_W  = DIV_W_DEF
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               en,
   input  logic [DIV_W-1:0]   baud_div,
   input  logic               parity_en,
   input  logic               parity_odd,
   fifo_uart_tx_if.master     fifo,
   output logic               tx,
   output logic               busy,
   output logic               frame_done
);

   localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

   state_e             r_state, w_nxt;
   logic [DATA_W-1:0]  r_shift;
   logic [IDX_W-1:0]   r_idx;
   logic [DIV_W-1:0]   r_div;
   logic               r_pen, r_par;
   logic               r_tx, r_busy, r_done;
   logic               w_bit_end, w_cnt_load, w_tx_nxt, w_pop, w_last_bit, w_more;
   logic [DIV_W-1:0]   w_cnt_val;

   assign w_last_bit = (r_idx == IDX_W'(DATA_W - 1));
   assign w_more     = en && !fifo.fifo_empty;

   // The divisor input is used directly only while loading; later bits reuse the latched copy.
   assign w_cnt_load = (r_state == ST_LOAD) ||
                       (w_bit_end && (r_state == ST_START || r_state == ST_DATA || r_state == ST_PARITY));
   assign w_cnt_val  = (r_state == ST_LOAD) ? baud_div : r_div;

   fifo_uart_tx_baud_counter #(.DIV_W(DIV_W)) u_baud (
      .clk       (clk),
      .rst       (rst),
      .i_load    (w_cnt_load),
      .i_div     (w_cnt_val),
      .o_bit_end (w_bit_end)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= ST_IDLE;
      else     r_state <= w_nxt;
   end

   always_comb begin
      w_nxt = r_state;
      unique case (r_state)
         ST_IDLE:   if (w_more) w_nxt = ST_POP;
         ST_POP:    w_nxt = ST_LOAD;
         ST_LOAD:   w_nxt = ST_START;
         ST_START:  if (w_bit_end) w_nxt = ST_DATA;
         ST_DATA:   if (w_bit_end && w_last_bit) w_nxt = r_pen ? ST_PARITY : ST_STOP;
         ST_PARITY: if (w_bit_end) w_nxt = ST_STOP;
         ST_STOP:   if (w_bit_end) w_nxt = w_more ? ST_POP : ST_IDLE;
         default:   w_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      w_pop    = 1'b0;
      w_tx_nxt = 1'b1;
      unique case (r_state)
         ST_POP:    w_pop    = 1'b1;
         ST_START:  w_tx_nxt = 1'b0;
         ST_DATA:   w_tx_nxt = r_shift[0];
         ST_PARITY: w_tx_nxt = r_par;
         default:   w_tx_nxt = 1'b1;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_shift <= '0;
         r_idx   <= '0;
         r_div   <= '0;
         r_pen   <= 1'b0;
         r_par   <= 1'b0;
      end else if (r_state == ST_LOAD) begin
         r_shift <= fifo.fifo_dout;
         r_idx   <= '0;
         r_div   <= baud_div;
         r_pen   <= parity_en;
         r_par   <= calc_parity(DATA_W_DEF'(fifo.fifo_dout), parity_odd);
      end else if (r_state == ST_DATA && w_bit_end) begin
         r_shift <= r_shift >> 1;
         r_idx   <= r_idx + IDX_W'(1);
      end
   end

   // Line and status are registered, so the line trails the state by one clock.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_tx   <= 1'b1;
         r_busy <= 1'b0;
         r_done <= 1'b0;
      end else begin
         r_tx   <= w_tx_nxt;
         r_busy <= (w_nxt != ST_IDLE);
         r_done <= (r_state == ST_STOP) && w_bit_end;
      end
   end

   assign fifo.pop_out = w_pop;
   assign tx           = r_tx;
   assign busy         = r_busy;
   assign frame_done   = r_done;

endmodule
